// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline event inputs and the stall/flush/bubble
// enables driven back into the pipeline registers and PC.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             EX_MemRead;
    logic [4:0]       EX_Rt;
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic             ID_Jump;
    logic             EX_BranchTaken;
    logic             MEM_Req;
    logic             MEM_Ready;
    logic             IRQ;

    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_Flush;
    logic             ID_EX_Bubble;
    logic             EX_MEM_Hold;
    logic             IRQ_Ack;
    logic             Mem_Timeout;
    logic [CNT_W-1:0] Stall_Count;
    logic [1:0]       State;

    modport master (
        output EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt, ID_Jump,
               EX_BranchTaken, MEM_Req, MEM_Ready, IRQ,
        input  PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, EX_MEM_Hold,
               IRQ_Ack, Mem_Timeout, Stall_Count, State
    );

    modport slave (
        input  EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt, ID_Jump,
               EX_BranchTaken, MEM_Req, MEM_Ready, IRQ,
        output PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, EX_MEM_Hold,
               IRQ_Ack, Mem_Timeout, Stall_Count, State
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer: load-use stalls, branch/jump flushes, memory wait
// holds with timeout, and interrupt drain-then-vector.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  sysclk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] MEM_WAIT  = 2'd1;
    localparam logic [1:0] IRQ_DRAIN = 2'd2;
    localparam logic [1:0] IRQ_VEC   = 2'd3;

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [3:0] DRAIN_VAL   = 4'(DRAIN_CYCLES);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [7:0]       wait_cnt;
    logic [7:0]       wait_nxt;
    logic [3:0]       drain_cnt;
    logic [3:0]       drain_nxt;
    logic             timeout_q;
    logic             timeout_set;
    logic [CNT_W-1:0] stall_cnt;

    logic mem_stall;
    logic load_use;
    logic run_rules;
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_ex_bubble;
    logic ex_mem_hold;
    logic irq_ack;

    assign mem_stall = bus.MEM_Req & ~bus.MEM_Ready;
    assign load_use  = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
                       ((bus.EX_Rt == bus.ID_Rs) ||
                        (bus.ID_UsesRt && (bus.EX_Rt == bus.ID_Rt)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_flush     = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        irq_ack      = 1'b0;
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        drain_nxt    = drain_cnt;
        timeout_set  = 1'b0;
        run_rules    = 1'b0;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_mem_hold = 1'b1;
                    state_nxt   = MEM_WAIT;
                    wait_nxt    = 8'd1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_stall && (wait_cnt == TIMEOUT_VAL)) begin
                    timeout_set = 1'b1;
                    state_nxt   = RUN;
                    run_rules   = 1'b1;
                end else if (mem_stall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_mem_hold = 1'b1;
                    wait_nxt    = wait_cnt + 8'd1;
                end else begin
                    state_nxt = RUN;
                    run_rules = 1'b1;
                end
            end
            IRQ_DRAIN: begin
                pc_write = 1'b0;
                if_flush = 1'b1;
                // A memory hold freezes the back end, so the drain count waits too.
                if (mem_stall) begin
                    ex_mem_hold = 1'b1;
                    if_id_write = 1'b0;
                end else if (drain_cnt == DRAIN_VAL) begin
                    state_nxt = IRQ_VEC;
                end else begin
                    drain_nxt = drain_cnt + 4'd1;
                end
            end
            default: begin
                irq_ack   = 1'b1;
                if_flush  = 1'b1;
                state_nxt = RUN;
            end
        endcase

        // Front-end rules shared by RUN and by every exit from MEM_WAIT.
        if (run_rules) begin
            if (bus.EX_BranchTaken) begin
                if_flush     = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (bus.ID_Jump) begin
                if_flush = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (bus.IRQ) begin
                if_flush  = 1'b1;
                pc_write  = 1'b0;
                state_nxt = IRQ_DRAIN;
                drain_nxt = 4'd1;
            end
        end

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_flush     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_hold  = 1'b0;
            irq_ack      = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            timeout_q <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.PC_Write     = pc_write;
    assign bus.IF_ID_Write  = if_id_write;
    assign bus.IF_Flush     = if_flush;
    assign bus.ID_EX_Bubble = id_ex_bubble;
    assign bus.EX_MEM_Hold  = ex_mem_hold;
    assign bus.IRQ_Ack      = irq_ack;
    assign bus.Mem_Timeout  = timeout_q;
    assign bus.Stall_Count  = stall_cnt;
    assign bus.State        = state;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed
// multi-cycle sequences, and randomized stimulus against a reference model.
module tb_pipeline_hazard_ctrl;
    // Narrow counter so saturation is reachable in a short run.
    localparam int unsigned TB_CNT_W     = 4;
    localparam int unsigned MEM_TIMEOUT  = 15;
    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int          SAT          = (1 << TB_CNT_W) - 1;

    // Output order: {PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, EX_MEM_Hold, IRQ_Ack}
    localparam logic [5:0] O_IDLE    = 6'b110000;
    localparam logic [5:0] O_HOLD    = 6'b000010;
    localparam logic [5:0] O_LU      = 6'b000100;
    localparam logic [5:0] O_BR      = 6'b111100;
    localparam logic [5:0] O_JMP     = 6'b111000;
    localparam logic [5:0] O_DRAIN   = 6'b011000;
    localparam logic [5:0] O_DRAIN_H = 6'b001010;
    localparam logic [5:0] O_VEC     = 6'b111001;
    localparam logic [5:0] O_RST     = 6'b001100;

    typedef struct packed {
        logic       mr;
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       jmp;
        logic       br;
        logic       req;
        logic       rdy;
        logic       irq;
    } in_t;

    typedef struct {
        string                name;
        in_t                  stim;
        logic [5:0]           exp_out;
        logic [1:0]           exp_state;
        logic [TB_CNT_W-1:0]  exp_cnt;
    } vec_t;

    logic sysclk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    in_t  zero_in;
    vec_t tbl[$];

    int m_mode;
    int m_waited;
    int m_drain_left;
    bit m_to;
    int m_stalls;

    pipeline_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .bus   (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    function automatic in_t mk(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt, input logic jmp,
                               input logic br, input logic req, input logic rdy, input logic irq);
        in_t v;
        v.mr = mr; v.ert = ert; v.rs = rs; v.rt = rt; v.urt = urt;
        v.jmp = jmp; v.br = br; v.req = req; v.rdy = rdy; v.irq = irq;
        return v;
    endfunction

    function automatic logic [5:0] outs();
        return {bus.PC_Write, bus.IF_ID_Write, bus.IF_Flush,
                bus.ID_EX_Bubble, bus.EX_MEM_Hold, bus.IRQ_Ack};
    endfunction

    function automatic logic [TB_CNT_W+2:0] regs();
        return {bus.State, bus.Mem_Timeout, bus.Stall_Count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        bus.EX_MemRead     = v.mr;
        bus.EX_Rt          = v.ert;
        bus.ID_Rs          = v.rs;
        bus.ID_Rt          = v.rt;
        bus.ID_UsesRt      = v.urt;
        bus.ID_Jump        = v.jmp;
        bus.EX_BranchTaken = v.br;
        bus.MEM_Req        = v.req;
        bus.MEM_Ready      = v.rdy;
        bus.IRQ            = v.irq;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(zero_in);
        @(posedge sysclk); #1;
        reset = 1'b0;
    endtask

    // One clock: drive, check combinational outputs mid-cycle, advance past the edge.
    task automatic cyc(input string name, input in_t v, input logic [5:0] exp);
        drive(v);
        @(negedge sysclk);
        check(name, 32'(outs()), 32'(exp));
        @(posedge sysclk); #1;
    endtask

    // Reference model: expected outputs for this cycle plus the state after the edge.
    task automatic model_cycle(input in_t v, input bit r, output logic [5:0] o,
                               output int n_mode, output int n_waited, output int n_drain,
                               output bit n_to, output int n_stalls);
        bit stalled;
        bit hazard;
        bit frontend;
        stalled  = v.req && !v.rdy;
        hazard   = v.mr && (v.ert != 5'd0) && ((v.ert == v.rs) || (v.urt && (v.ert == v.rt)));
        n_mode   = m_mode;
        n_waited = m_waited;
        n_drain  = m_drain_left;
        n_to     = m_to;
        n_stalls = m_stalls;
        o        = O_IDLE;
        frontend = 1'b0;
        if (r) begin
            o = O_RST; n_mode = 0; n_waited = 0; n_drain = 0; n_to = 1'b0; n_stalls = 0;
            return;
        end
        case (m_mode)
            0: if (stalled) begin o = O_HOLD; n_mode = 1; n_waited = 1; end
               else frontend = 1'b1;
            1: if (stalled && (m_waited == int'(MEM_TIMEOUT))) begin
                   n_to = 1'b1; n_mode = 0; frontend = 1'b1;
               end else if (stalled) begin
                   o = O_HOLD; n_waited = m_waited + 1;
               end else begin
                   n_mode = 0; frontend = 1'b1;
               end
            2: if (stalled) o = O_DRAIN_H;
               else begin
                   o = O_DRAIN;
                   n_drain = m_drain_left - 1;
                   if (n_drain == 0) n_mode = 3;
               end
            default: begin o = O_VEC; n_mode = 0; end
        endcase
        if (frontend) begin
            if (v.br)        o = O_BR;
            else if (v.jmp)  o = O_JMP;
            else if (hazard) o = O_LU;
            else if (v.irq) begin
                o = O_DRAIN; n_mode = 2; n_drain = int'(DRAIN_CYCLES);
            end
        end
        if (!o[5] && (n_stalls < SAT)) n_stalls++;
    endtask

    initial begin
        logic [5:0]          mo;
        logic [TB_CNT_W+8:0] mexp;
        int                  nm, nw, nd, ns;
        bit                  nt;
        bit                  r;
        in_t                 v;

        n_cmp   = 0;
        n_bad   = 0;
        zero_in = '0;

        tbl.push_back('{"idle",         mk(0,5'd0,5'd0,5'd0,0,0,0,0,0,0), O_IDLE,  2'd0, 4'd0});
        tbl.push_back('{"lu_rs",        mk(1,5'd8,5'd8,5'd0,0,0,0,0,0,0), O_LU,    2'd0, 4'd1});
        tbl.push_back('{"lu_r0",        mk(1,5'd0,5'd0,5'd0,1,0,0,0,0,0), O_IDLE,  2'd0, 4'd0});
        tbl.push_back('{"lu_rt",        mk(1,5'd5,5'd1,5'd5,1,0,0,0,0,0), O_LU,    2'd0, 4'd1});
        tbl.push_back('{"rt_unused",    mk(1,5'd5,5'd1,5'd5,0,0,0,0,0,0), O_IDLE,  2'd0, 4'd0});
        tbl.push_back('{"no_load",      mk(0,5'd8,5'd8,5'd8,1,0,0,0,0,0), O_IDLE,  2'd0, 4'd0});
        tbl.push_back('{"br_over_lu",   mk(1,5'd8,5'd8,5'd0,0,0,1,0,0,0), O_BR,    2'd0, 4'd0});
        tbl.push_back('{"jmp",          mk(0,5'd0,5'd0,5'd0,0,1,0,0,0,0), O_JMP,   2'd0, 4'd0});
        tbl.push_back('{"br_over_jmp",  mk(0,5'd0,5'd0,5'd0,0,1,1,0,0,0), O_BR,    2'd0, 4'd0});
        tbl.push_back('{"jmp_over_lu",  mk(1,5'd8,5'd8,5'd0,0,1,0,0,0,0), O_JMP,   2'd0, 4'd0});
        tbl.push_back('{"mem_over_br",  mk(0,5'd0,5'd0,5'd0,0,1,1,1,0,0), O_HOLD,  2'd1, 4'd1});
        tbl.push_back('{"mem_ready",    mk(0,5'd0,5'd0,5'd0,0,0,0,1,1,0), O_IDLE,  2'd0, 4'd0});
        tbl.push_back('{"irq",          mk(0,5'd0,5'd0,5'd0,0,0,0,0,0,1), O_DRAIN, 2'd2, 4'd1});
        tbl.push_back('{"jmp_over_irq", mk(0,5'd0,5'd0,5'd0,0,1,0,0,0,1), O_JMP,   2'd0, 4'd0});
        tbl.push_back('{"lu_over_irq",  mk(1,5'd8,5'd8,5'd0,0,0,0,0,0,1), O_LU,    2'd0, 4'd1});
        tbl.push_back('{"mem_over_irq", mk(0,5'd0,5'd0,5'd0,0,0,0,1,0,1), O_HOLD,  2'd1, 4'd1});

        // Reset state and forced output pattern
        reset = 1'b1;
        drive(zero_in);
        @(negedge sysclk);
        check("reset_outs", 32'(outs()), 32'(O_RST));
        @(posedge sysclk); #1;
        check("reset_regs", 32'(regs()), 32'({2'd0, 1'b0, 4'd0}));
        reset = 1'b0;

        foreach (tbl[i]) begin
            do_reset();
            drive(tbl[i].stim);
            @(negedge sysclk);
            check(tbl[i].name, 32'(outs()), 32'(tbl[i].exp_out));
            @(posedge sysclk); #1;
            check({tbl[i].name, "_regs"}, 32'(regs()),
                  32'({tbl[i].exp_state, 1'b0, tbl[i].exp_cnt}));
        end

        // Memory wait: ready low for four cycles then high
        do_reset();
        drive(mk(0,5'd0,5'd0,5'd0,0,0,0,1,0,0));
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            check("memwait_hold", 32'(outs()), 32'(O_HOLD));
            @(posedge sysclk); #1;
            check("memwait_state", 32'(bus.State), 32'd1);
        end
        bus.MEM_Ready = 1'b1;
        @(negedge sysclk);
        check("memwait_release", 32'(outs()), 32'(O_IDLE));
        @(posedge sysclk); #1;
        check("memwait_done", 32'(regs()), 32'({2'd0, 1'b0, 4'd4}));

        // Timeout: fifteen hold cycles, then the hold drops and the flag sticks
        do_reset();
        drive(mk(0,5'd0,5'd0,5'd0,0,0,0,1,0,0));
        for (int i = 0; i < 15; i++) begin
            @(negedge sysclk);
            check("timeout_hold", 32'(outs()), 32'(O_HOLD));
            @(posedge sysclk); #1;
        end
        @(negedge sysclk);
        check("timeout_release", 32'(outs()), 32'(O_IDLE));
        check("timeout_flag_pre", 32'(bus.Mem_Timeout), 32'd0);
        @(posedge sysclk); #1;
        check("timeout_regs", 32'(regs()), 32'({2'd0, 1'b1, 4'd15}));
        drive(zero_in);
        repeat (3) @(posedge sysclk);
        #1;
        check("timeout_sticky", 32'(bus.Mem_Timeout), 32'd1);
        cyc("sat_lu", mk(1,5'd8,5'd8,5'd0,0,0,0,0,0,0), O_LU);
        check("stall_saturate", 32'(bus.Stall_Count), 32'd15);

        // Reset during MEM_WAIT with the timeout flag already set
        cyc("rw_stall0", mk(0,5'd0,5'd0,5'd0,0,0,0,1,0,0), O_HOLD);
        cyc("rw_stall1", mk(0,5'd0,5'd0,5'd0,0,0,0,1,0,0), O_HOLD);
        check("rw_state", 32'(bus.State), 32'd1);
        reset = 1'b1;
        @(negedge sysclk);
        check("rw_reset_outs", 32'(outs()), 32'(O_RST));
        @(posedge sysclk); #1;
        check("rw_reset_regs", 32'(regs()), 32'({2'd0, 1'b0, 4'd0}));
        reset = 1'b0;
        drive(zero_in);

        // Interrupt: entry, three drain cycles (jumps ignored), one vector cycle
        do_reset();
        cyc("irq_entry", mk(0,5'd0,5'd0,5'd0,0,0,0,0,0,1), O_DRAIN);
        for (int i = 0; i < 3; i++)
            cyc("irq_drain", mk(0,5'd0,5'd0,5'd0,0,1,1,0,0,1), O_DRAIN);
        cyc("irq_vec", mk(0,5'd0,5'd0,5'd0,0,0,0,0,0,1), O_VEC);
        cyc("irq_after", zero_in, O_IDLE);
        check("irq_regs", 32'(regs()), 32'({2'd0, 1'b0, 4'd4}));

        // Interrupt with a two-cycle memory stall mid-drain
        cyc("irq2_entry", mk(0,5'd0,5'd0,5'd0,0,0,0,0,0,1), O_DRAIN);
        cyc("irq2_drain1", zero_in, O_DRAIN);
        cyc("irq2_hold", mk(0,5'd0,5'd0,5'd0,0,0,0,1,0,0), O_DRAIN_H);
        cyc("irq2_hold", mk(0,5'd0,5'd0,5'd0,0,0,0,1,0,0), O_DRAIN_H);
        check("irq2_hold_state", 32'(bus.State), 32'd2);
        cyc("irq2_drain2", zero_in, O_DRAIN);
        cyc("irq2_drain3", zero_in, O_DRAIN);
        cyc("irq2_vec", zero_in, O_VEC);
        cyc("irq2_after", zero_in, O_IDLE);
        check("irq2_regs", 32'(regs()), 32'({2'd0, 1'b0, 4'd10}));

        // Reset during drain abandons the interrupt without an ack
        do_reset();
        cyc("ra_entry", mk(0,5'd0,5'd0,5'd0,0,0,0,0,0,1), O_DRAIN);
        cyc("ra_drain", zero_in, O_DRAIN);
        do_reset();
        for (int i = 0; i < 4; i++) cyc("ra_no_ack", zero_in, O_IDLE);

        // Randomized traffic against the reference model
        do_reset();
        m_mode = 0; m_waited = 0; m_drain_left = 0; m_to = 1'b0; m_stalls = 0;
        for (int i = 0; i < 3000; i++) begin
            v.mr  = 1'($urandom_range(0, 1));
            v.ert = 5'($urandom_range(0, 3));
            v.rs  = 5'($urandom_range(0, 3));
            v.rt  = 5'($urandom_range(0, 3));
            v.urt = 1'($urandom_range(0, 1));
            v.jmp = ($urandom_range(0, 7) == 0);
            v.br  = ($urandom_range(0, 7) == 0);
            v.req = ($urandom_range(0, 2) == 0);
            v.rdy = ($urandom_range(0, 2) == 0);
            v.irq = ($urandom_range(0, 15) == 0);
            if ((i % 400) >= 378) begin
                v.req = 1'b1;
                v.rdy = 1'b0;
            end
            r = ($urandom_range(0, 99) == 0);
            reset = r;
            drive(v);
            @(negedge sysclk);
            model_cycle(v, r, mo, nm, nw, nd, nt, ns);
            mexp = {mo, 2'(m_mode), m_to, TB_CNT_W'(m_stalls)};
            check("random", 32'({outs(), regs()}), 32'(mexp));
            @(posedge sysclk); #1;
            m_mode = nm; m_waited = nw; m_drain_left = nd; m_to = nt; m_stalls = ns;
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
